sram_responder: RTL and testbench

//  Cycle-accurate synthesizable model of the external 16-bit asynchronous SRAM.

---
 rtl/sram_responder.sv | 197 +++++++++++++++++++
 tb/tb_sram_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// sram_responder
//   Cycle-accurate stand-in for an external 16-bit asynchronous SRAM. It sits
//   on the SRAM side of a memory controller, stores every word written on a
//   write edge, and returns read data with a configurable pipeline latency and
//   a write-to-read bus turnaround gap during which DQ stays released.
//
// Parameters
//   ADDR_W    word address width; the array holds 2**ADDR_W 16-bit words
//   READ_LAT  0 = combinational array read, 1..3 = registered read pipeline
//   TURN_CYC  turnaround length after the last write edge (0..7)
//
// Ports
//   clk        in     single clock, all state updates on posedge
//   rst_n      in     asynchronous active-low reset
//   SRAM_ADDR  in     word address from the controller
//   SRAM_WE_N  in     active-low write enable
//   SRAM_DQ    inout  bidirectional data, driven only while dq_oe=1
//   dq_oe      out    responder is driving SRAM_DQ
//   rd_count   out    driven read-beat count (statistics build only, else 0)
//   wr_count   out    write-beat count (statistics build only, else 0)
//
// Build option
//   SRAM_RESP_STATS_EN  when defined, builds the saturating read/write beat
//                       counters; when undefined both counts are tied to 0.

module sram_responder #(
  parameter int ADDR_W   = 18,
  parameter int READ_LAT = 0,
  parameter int TURN_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic              SRAM_WE_N,
  inout  wire  [15:0]       SRAM_DQ,
  output logic              dq_oe,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  localparam int DEPTH = 1 << ADDR_W;

  // Value loaded into the turnaround counter when leaving S_WR; the counter
  // runs TURN_CYC-1 down to 0 so S_TURN lasts exactly TURN_CYC clocks.
  localparam logic [2:0] TURN_LOAD = (TURN_CYC > 0) ? 3'(TURN_CYC - 1) : 3'd0;

  typedef enum logic [1:0] {
    S_RD   = 2'd0,
    S_WR   = 2'd1,
    S_TURN = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nx_s;
  logic [2:0]  turn_cnt_r;
  logic [2:0]  turn_cnt_nx_s;

  logic [15:0] mem [DEPTH];

  logic [15:0] rd_data_s;
  logic        rd_valid_s;

  // ---------------------------------------------------------------------------
  // Storage array. Not reset: contents are undefined until written. An edge
  // that coincides with reset asserted performs no write.
  // ---------------------------------------------------------------------------

  // Array write port: one word per posedge with WE_N low.
  always_ff @(posedge clk) begin
    if (rst_n && !SRAM_WE_N) begin
      mem[SRAM_ADDR] <= SRAM_DQ;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  generate
    if (READ_LAT == 0) begin : g_comb_read
      // A write stored at an edge is visible to this read right after it.
      assign rd_data_s  = mem[SRAM_ADDR];
      assign rd_valid_s = 1'b1;
    end else begin : g_pipe_read
      logic [15:0]         pipe_data_r  [READ_LAT];
      logic [READ_LAT-1:0] pipe_valid_r;

      // Read pipeline: stage 0 captures the array word, later stages shift.
      // A write edge injects an invalid bubble so stale data is never driven.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < READ_LAT; i++) begin
            pipe_data_r[i] <= 16'h0000;
          end
          pipe_valid_r <= '0;
        end else begin
          pipe_data_r[0]  <= mem[SRAM_ADDR];
          pipe_valid_r[0] <= SRAM_WE_N;
          for (int i = 1; i < READ_LAT; i++) begin
            pipe_data_r[i]  <= pipe_data_r[i-1];
            pipe_valid_r[i] <= pipe_valid_r[i-1];
          end
        end
      end

      assign rd_data_s  = pipe_data_r[READ_LAT-1];
      assign rd_valid_s = pipe_valid_r[READ_LAT-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Turnaround FSM: keeps DQ released for a while after the controller stops
  // writing, so the controller's own drivers can turn off first.
  // ---------------------------------------------------------------------------

  // FSM state and turnaround counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_RD;
      turn_cnt_r <= 3'd0;
    end else begin
      state_r    <= state_nx_s;
      turn_cnt_r <= turn_cnt_nx_s;
    end
  end

  // FSM next-state logic; a write edge wins from any state.
  always_comb begin
    state_nx_s    = state_r;
    turn_cnt_nx_s = turn_cnt_r;
    if (!SRAM_WE_N) begin
      state_nx_s    = S_WR;
      turn_cnt_nx_s = 3'd0;
    end else begin
      case (state_r)
        S_WR: begin
          if (TURN_CYC == 0) begin
            state_nx_s = S_RD;
          end else begin
            state_nx_s    = S_TURN;
            turn_cnt_nx_s = TURN_LOAD;
          end
        end
        S_TURN: begin
          if (turn_cnt_r == 3'd0) begin
            state_nx_s = S_RD;
          end else begin
            turn_cnt_nx_s = turn_cnt_r - 3'd1;
          end
        end
        S_RD: begin
          state_nx_s = S_RD;
        end
        default: begin
          state_nx_s    = S_RD;
          turn_cnt_nx_s = 3'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // DQ drive. Deliberately combinational in rst_n and WE_N: reset releases
  // the bus immediately and a low WE_N can never collide with our driver.
  // ---------------------------------------------------------------------------
  assign dq_oe   = rst_n & SRAM_WE_N & (state_r == S_RD) & rd_valid_s;
  assign SRAM_DQ = dq_oe ? rd_data_s : 16'hzzzz;

  // ---------------------------------------------------------------------------
  // Optional beat statistics
  // ---------------------------------------------------------------------------
`ifdef SRAM_RESP_STATS_EN
  logic [15:0] rd_count_r;
  logic [15:0] wr_count_r;

  // Saturating beat counters; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_r <= 16'h0000;
      wr_count_r <= 16'h0000;
    end else begin
      if (!SRAM_WE_N && (wr_count_r != 16'hFFFF)) begin
        wr_count_r <= wr_count_r + 16'd1;
      end
      if (dq_oe && (rd_count_r != 16'hFFFF)) begin
        rd_count_r <= rd_count_r + 16'd1;
      end
    end
  end

  assign rd_count = rd_count_r;
  assign wr_count = wr_count_r;
`else
  assign rd_count = 16'h0000;
  assign wr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder. Instance "dut" uses the default 18-bit
// array with a combinational read and a two-clock turnaround; instance
// "dut_p" uses a small array with a two-stage read pipeline and a one-clock
// turnaround. Inputs change 1 ns after the rising edge; outputs are checked
// 1 ns after that or later, never on the edge itself.

module tb_sram_responder;

  logic clk;
  int   n_checks;
  int   n_errors;

`ifdef SRAM_RESP_STATS_EN
  localparam logic [15:0] EXP_WR = 16'd4;
  localparam logic [15:0] EXP_RD = 16'd5;
`else
  localparam logic [15:0] EXP_WR = 16'd0;
  localparam logic [15:0] EXP_RD = 16'd0;
`endif

  // Instance A: ADDR_W=18, READ_LAT=0, TURN_CYC=2
  logic        a_rst_n;
  logic [17:0] a_addr;
  logic        a_we_n;
  logic [15:0] a_drv;
  logic        a_drv_en;
  wire  [15:0] a_dq;
  logic        a_oe;
  logic [15:0] a_rd_cnt;
  logic [15:0] a_wr_cnt;

  // Instance B: ADDR_W=4, READ_LAT=2, TURN_CYC=1
  logic        b_rst_n;
  logic [3:0]  b_addr;
  logic        b_we_n;
  logic [15:0] b_drv;
  logic        b_drv_en;
  wire  [15:0] b_dq;
  logic        b_oe;
  logic [15:0] b_rd_cnt;
  logic [15:0] b_wr_cnt;

  assign a_dq = a_drv_en ? a_drv : 16'hzzzz;
  assign b_dq = b_drv_en ? b_drv : 16'hzzzz;

  sram_responder #(.ADDR_W(18), .READ_LAT(0), .TURN_CYC(2)) dut (
    .clk       (clk),
    .rst_n     (a_rst_n),
    .SRAM_ADDR (a_addr),
    .SRAM_WE_N (a_we_n),
    .SRAM_DQ   (a_dq),
    .dq_oe     (a_oe),
    .rd_count  (a_rd_cnt),
    .wr_count  (a_wr_cnt)
  );

  sram_responder #(.ADDR_W(4), .READ_LAT(2), .TURN_CYC(1)) dut_p (
    .clk       (clk),
    .rst_n     (b_rst_n),
    .SRAM_ADDR (b_addr),
    .SRAM_WE_N (b_we_n),
    .SRAM_DQ   (b_dq),
    .dq_oe     (b_oe),
    .rd_count  (b_rd_cnt),
    .wr_count  (b_wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One write beat on instance A; also checks the responder lets go of DQ
  // combinationally while WE_N is low.
  task automatic wr_a(input logic [17:0] addr, input logic [15:0] data);
    a_addr   = addr;
    a_drv    = data;
    a_drv_en = 1'b1;
    a_we_n   = 1'b0;
    #1;
    check("a_oe_we_low", {15'd0, a_oe}, 16'd0);
    @(posedge clk); #1;
    a_we_n   = 1'b1;
    a_drv_en = 1'b0;
  endtask

  task automatic wr_b(input logic [3:0] addr, input logic [15:0] data);
    b_addr   = addr;
    b_drv    = data;
    b_drv_en = 1'b1;
    b_we_n   = 1'b0;
    @(posedge clk); #1;
    b_we_n   = 1'b1;
    b_drv_en = 1'b0;
  endtask

  // Let the two-clock turnaround of instance A expire (S_WR, then 2 x S_TURN).
  task automatic turn_a();
    repeat (3) @(posedge clk);
    #1;
  endtask

  logic [15:0] b_words [4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    a_rst_n = 1'b0; a_addr = 18'd0; a_we_n = 1'b1; a_drv = 16'h0000; a_drv_en = 1'b0;
    b_rst_n = 1'b0; b_addr = 4'd0;  b_we_n = 1'b1; b_drv = 16'h0000; b_drv_en = 1'b0;
    b_words[0] = 16'h1357; b_words[1] = 16'h2468;
    b_words[2] = 16'h9ABC; b_words[3] = 16'hDEF0;

    // Reset state
    #3;
    check("rst_oe",     {15'd0, a_oe}, 16'd0);
    check("rst_rd_cnt", a_rd_cnt, 16'h0000);
    check("rst_wr_cnt", a_wr_cnt, 16'h0000);
    #9;
    a_rst_n = 1'b1;

    // Two single writes, then the turnaround keeps DQ released for the
    // S_WR clock plus TURN_CYC=2 clocks of S_TURN.
    wr_a(18'h00010, 16'hBEEF);
    wr_a(18'h00011, 16'hCAFE);
    a_addr = 18'h00010;
    #1;
    check("turn_s_wr", {15'd0, a_oe}, 16'd0);
    @(posedge clk); #1;
    check("turn_1", {15'd0, a_oe}, 16'd0);
    @(posedge clk); #1;
    check("turn_2", {15'd0, a_oe}, 16'd0);
    @(posedge clk); #1;
    check("turn_done", {15'd0, a_oe}, 16'd1);
    check("rd_beef", a_dq, 16'hBEEF);
    a_addr = 18'h00011;
    #1;
    check("rd_cafe", a_dq, 16'hCAFE);

    // Top and bottom of the address space are distinct words
    wr_a(18'h00000, 16'h5A5A);
    wr_a(18'h3FFFF, 16'h1234);
    turn_a();
    a_addr = 18'h3FFFF;
    #1;
    check("rd_top", a_dq, 16'h1234);
    a_addr = 18'h00000;
    #1;
    check("rd_bottom", a_dq, 16'h5A5A);

    // Overwrite then read back, and back-to-back write edges
    wr_a(18'h00010, 16'h0F0F);
    wr_a(18'h00020, 16'hA0A0);
    wr_a(18'h00021, 16'hB1B1);
    turn_a();
    a_addr = 18'h00010;
    #1;
    check("rd_overwrite", a_dq, 16'h0F0F);
    a_addr = 18'h00020;
    #1;
    check("rd_burst0", a_dq, 16'hA0A0);
    a_addr = 18'h00021;
    #1;
    check("rd_burst1", a_dq, 16'hB1B1);
    check("oe_reading", {15'd0, a_oe}, 16'd1);

    // Reset while driving: bus released at once
    a_rst_n = 1'b0;
    #1;
    check("rst_mid_read_oe", {15'd0, a_oe}, 16'd0);
    // A write edge while reset is low must not store
    a_addr = 18'h00010; a_drv = 16'hDEAD; a_drv_en = 1'b1; a_we_n = 1'b0;
    @(posedge clk); #1;
    check("rst_cnt_rd", a_rd_cnt, 16'h0000);
    check("rst_cnt_wr", a_wr_cnt, 16'h0000);

    // Four write edges then five driven read edges
    a_addr = 18'h00030; a_drv = 16'h3000;
    a_rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a_addr = 18'h00030 + 18'(k);
      a_drv  = 16'h3000 + 16'(k);
      @(posedge clk); #1;
    end
    a_we_n = 1'b1; a_drv_en = 1'b0;
    turn_a();
    a_addr = 18'h00010;
    #1;
    check("rd_after_rst", a_dq, 16'h0F0F);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      a_addr = 18'h00030 + 18'(k);
      #1;
      check("rd_stat_word", a_dq, 16'h3000 + 16'(k));
      @(posedge clk); #1;
    end
    check("stat_wr", a_wr_cnt, EXP_WR);
    check("stat_rd", a_rd_cnt, EXP_RD);
    a_rst_n = 1'b0;
    #1;
    check("stat_clr_wr", a_wr_cnt, 16'h0000);
    check("stat_clr_rd", a_rd_cnt, 16'h0000);

    // Pipelined instance: valid bits are clear out of reset
    @(posedge clk); #1;
    b_rst_n = 1'b1;
    #1;
    check("b_rst_oe", {15'd0, b_oe}, 16'd0);
    for (int k = 0; k < 4; k++) begin
      wr_b(4'(k), b_words[k]);
    end
    // Address k presented before edge e=k+1; its word appears after edge k+2.
    for (int e = 1; e <= 5; e++) begin
      if (e <= 4) begin
        b_addr = 4'(e - 1);
      end else begin
        b_addr = 4'd0;
      end
      @(posedge clk); #1;
      if (e == 1) begin
        check("b_turn_oe", {15'd0, b_oe}, 16'd0);
      end else begin
        check("b_pipe_oe", {15'd0, b_oe}, 16'd1);
        check("b_pipe_data", b_dq, b_words[e-2]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
